fifo_wr_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/b2g_decoder.sv | 11 +
 rtl/fifo_wr_ctrl_gray_sync.sv | 29 ++
 rtl/g2b_decoder.sv | 14 +
 rtl/fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizes for the 8-entry gray-code async FIFO.
//   PTR_W / ADDR_W / DEPTH : pointer width (with wrap bit), RAM address width, entries
//   SYNC_STAGES            : read-pointer synchronizer depth, 3 when FIFO_WR_SYNC3_EN
//                            is defined, otherwise 2
package fifo_pkg;
  localparam int PTR_W  = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

`ifdef FIFO_WR_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/b2g_decoder.sv
// b2g_decoder: 4-bit binary to gray conversion (purely combinational).
//   bin  : binary input
//   gray : gray-coded output
module b2g_decoder
  import fifo_pkg::*;
(
  input  logic [3:0] bin,
  output logic [3:0] gray
);
  assign gray = bin ^ {1'b0, bin[3:1]};
endmodule

// File: rtl/fifo_wr_ctrl_gray_sync.sv
// gray_sync: N-stage bus synchronizer for a gray-coded pointer. Safe for a
// multi-bit bus only because the source changes at most one bit per cycle.
//   clk, rst_n : destination clock, async active-low reset
//   d          : asynchronous gray input
//   q          : synchronized output (STAGES edges of latency)
module gray_sync
  import fifo_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  ptr_t d,
  output ptr_t q
);
  ptr_t stage_r [STAGES];

  // Shift register of synchronizer flops; stage 0 is the metastable capture flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_r[i] <= 4'b0000;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[STAGES-1];
endmodule

// File: rtl/g2b_decoder.sv
// g2b_decoder: 4-bit gray to binary conversion (purely combinational).
//   gray : gray-coded input
//   bin  : binary output
module g2b_decoder
  import fifo_pkg::*;
(
  input  logic [3:0] gray,
  output logic [3:0] bin
);
  assign bin[3] = gray[3];
  assign bin[2] = gray[3] ^ gray[2];
  assign bin[1] = gray[3] ^ gray[2] ^ gray[1];
  assign bin[0] = gray[3] ^ gray[2] ^ gray[1] ^ gray[0];
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer controller of the 8-entry gray-code async FIFO.
// Optional feature: define FIFO_WR_SYNC3_EN for a 3-stage read-pointer synchronizer.
//   clk, rst_n          : write clock, async active-low reset
//   push_valid/ready    : producer handshake (ready = !full)
//   clr_ovf             : synchronous clear of the sticky overflow flag
//   rptr_gray           : read-domain gray pointer (asynchronous, synchronized here)
//   wr_en, wr_addr      : RAM write strobe and address
//   wptr_gray           : registered gray write pointer to the read domain
//   full, almost_full   : occupancy flags (pessimistic, derived from flops only)
//   level               : write-side occupancy 0..8
//   overflow            : sticky, set by a push attempt while full
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_W    = 4,
  parameter int AFULL_TH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             clr_ovf,
  input  logic [PTR_W-1:0] rptr_gray,
  output logic             wr_en,
  output logic [2:0]       wr_addr,
  output logic [PTR_W-1:0] wptr_gray,
  output logic             full,
  output logic             almost_full,
  output logic [PTR_W-1:0] level,
  output logic             overflow
);
  localparam logic [PTR_W-1:0] AFULL_LVL = AFULL_TH[PTR_W-1:0];

  logic [PTR_W-1:0] wptr_bin_r;
  logic [PTR_W-1:0] wptr_gray_r;
  logic             overflow_r;
  logic [PTR_W-1:0] wptr_bin_nxt_s;
  logic [PTR_W-1:0] wptr_gray_nxt_s;
  logic [PTR_W-1:0] rptr_sync_s;
  logic [PTR_W-1:0] rptr_bin_s;
  logic             full_s;
  logic             wr_en_s;

  // Accept handshake and next binary pointer.
  always_comb begin
    wr_en_s        = push_valid && !full_s;
    wptr_bin_nxt_s = wptr_bin_r;
    if (wr_en_s) begin
      wptr_bin_nxt_s = wptr_bin_r + 4'd1;
    end else begin
      wptr_bin_nxt_s = wptr_bin_r;
    end
  end

  // Gray is taken from the next-state binary so both pointers move on the same edge.
  b2g_decoder u_b2g (
    .bin  (wptr_bin_nxt_s),
    .gray (wptr_gray_nxt_s)
  );

  gray_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray),
    .q     (rptr_sync_s)
  );

  g2b_decoder u_g2b (
    .gray (rptr_sync_s),
    .bin  (rptr_bin_s)
  );

  // Write pointer registers, binary and gray.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin_r  <= 4'b0000;
      wptr_gray_r <= 4'b0000;
    end else begin
      wptr_bin_r  <= wptr_bin_nxt_s;
      wptr_gray_r <= wptr_gray_nxt_s;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (push_valid && full_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Full when the pointers match except for the two MSBs of the gray code,
  // which is the gray-domain image of "binary differs only in the wrap bit".
  assign full_s      = (wptr_gray_r == {~rptr_sync_s[3:2], rptr_sync_s[1:0]});
  assign level       = wptr_bin_r - rptr_bin_s;
  assign almost_full = (level >= AFULL_LVL);
  assign full        = full_s;
  assign push_ready  = !full_s;
  assign wr_en       = wr_en_s;
  assign wr_addr     = wptr_bin_r[2:0];
  assign wptr_gray   = wptr_gray_r;
  assign overflow    = overflow_r;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;
`ifdef FIFO_WR_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif
  localparam int AFULL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push_valid;
  logic       push_ready;
  logic       clr_ovf;
  logic [3:0] rptr_gray;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;

  fifo_wr_ctrl #(.PTR_W(4), .AFULL_TH(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
    .clr_ovf(clr_ovf), .rptr_gray(rptr_gray), .wr_en(wr_en), .wr_addr(wr_addr),
    .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: counts of words written and read, the read count as seen
  // through the synchronizer delay line, and the sticky overflow bit.
  int wcount;
  int rcount;
  int rhist [SYNC];
  bit m_ovf;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] prev_gray;

  function automatic logic [3:0] to_gray(int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int m_level();
    return wcount - rhist[SYNC-1];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wcount = 0;
    rcount = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < SYNC; i++) rhist[i] = 0;
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(m_level()));
    chk("full", 32'(full), 32'(m_level() == 8));
    chk("almost_full", 32'(almost_full), 32'(m_level() >= AFULL));
    chk("push_ready", 32'(push_ready), 32'(m_level() != 8));
    chk("wptr_gray", 32'(wptr_gray), 32'(to_gray(wcount)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock cycle: combinational checks on current inputs, edge, model update, state checks.
  task automatic step();
    bit m_full;
    #1;
    m_full = (m_level() == 8);
    chk("wr_en", 32'(wr_en), 32'(push_valid && !m_full));
    chk("wr_addr", 32'(wr_addr), 32'(wcount % 8));
    @(posedge clk);
    if (push_valid && !m_full) wcount++;
    if (push_valid && m_full) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    for (int i = SYNC - 1; i > 0; i--) rhist[i] = rhist[i-1];
    rhist[0] = rcount;
    #1;
    check_state();
  endtask

  task automatic set_rd(int n);
    rcount = n;
    rptr_gray = to_gray(n);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; push_valid = 1'b1; clr_ovf = 1'b0; rptr_gray = 4'b0000;
    #2;
    check_state();
    chk("rst_wr_en", 32'(wr_en), 32'd1);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    #10 rst_n = 1'b1;

    // Fill from empty: 8 pushes with the read pointer parked at 0.
    for (int i = 0; i < 8; i++) step();
    chk("fill_gray", 32'(wptr_gray), 32'(4'b1100));
    chk("fill_full", 32'(full), 32'd1);

    // Overflow: keep pushing while full for two cycles.
    step();
    step();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    push_valid = 1'b0;

    // Release latency: one read; full must drop exactly SYNC edges later.
    set_rd(1);
    for (int i = 0; i < SYNC; i++) begin
      step();
      chk("release_full", 32'(full), 32'(i != SYNC - 1));
    end
    chk("release_level", 32'(level), 32'd7);

    // Clear overflow while not full.
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Randomized streaming with a lockstep-ish reader across several wraps.
    prev_gray = wptr_gray;
    for (int i = 0; i < 90; i++) begin
      push_valid = ($urandom_range(3) != 0);
      if (rcount < wcount && $urandom_range(1) == 1) set_rd(rcount + 1);
      step();
      chk("gray_1bit", 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
      chk("level_max", 32'(level <= 4'd8), 32'd1);
      prev_gray = wptr_gray;
    end
    chk("wrapped", 32'(wcount > 32), 32'd1);

    // Simultaneous push and read advance at level 7.
    push_valid = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    for (int i = 0; i < 40 && (wcount - rcount) != 7; i++) begin
      push_valid = 1'b0;
      if (wcount - rcount > 7) set_rd(rcount + 1);
      else push_valid = 1'b1;
      step();
    end
    push_valid = 1'b0;
    for (int i = 0; i < SYNC; i++) step();
    chk("simul_lvl7", 32'(level), 32'd7);
    push_valid = 1'b1;
    set_rd(rcount + 1);
    step();
    chk("simul_lvl8", 32'(level), 32'd8);
    push_valid = 1'b0;
    for (int i = 0; i < SYNC; i++) step();
    chk("simul_back7", 32'(level), 32'd7);
    chk("simul_no_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a push burst: no clock edge needed.
    push_valid = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    rptr_gray = 4'b0000;
    model_reset();
    #1;
    check_state();
    chk("midrst_wr_en", 32'(wr_en), 32'd1);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    push_valid = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_addr", 32'(wr_addr), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
